// File: rtl/gray_counter_conv.sv
// gray_counter_conv: loadable up/down counter that keeps registered binary and
// Gray copies of its count, plus a valid-tagged, one-cycle binary<->Gray
// conversion channel.
// Build option: define GRAY_COUNTER_DECODE_EN to build the Gray->binary
// decoder and honour conv_mode. Without it the channel is encode-only and
// conv_mode has no effect.
module gray_counter_conv #(
  parameter int WIDTH = 4,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap,
  input  logic             conv_valid_in,
  input  logic             conv_mode,
  input  logic [WIDTH-1:0] conv_din,
  output logic             conv_valid_out,
  output logic [WIDTH-1:0] conv_dout
);

  localparam logic [WIDTH-1:0] INIT_BIN = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

`ifdef GRAY_COUNTER_DECODE_EN
  // Prefix-XOR from the MSB down: each binary bit is the parity of all Gray
  // bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
`endif

  logic [WIDTH-1:0] bin_p1;
  logic [WIDTH-1:0] gray_p1;
  logic             wrap_p1;
  logic [WIDTH-1:0] bin_nxt;
  logic             wrap_nxt;
  logic             vld_p1;
  logic [WIDTH-1:0] conv_p1;
  logic [WIDTH-1:0] conv_res;

  // Counter next state: load beats count, count beats hold; wrap flags the
  // single step that crosses the all-ones/zero boundary.
  always_comb begin
    bin_nxt  = bin_p1;
    wrap_nxt = 1'b0;
    if (load) begin
      bin_nxt = load_bin;
    end else if (en) begin
      if (up) begin
        bin_nxt  = bin_p1 + ONE;
        wrap_nxt = (bin_p1 == ALL_ONES);
      end else begin
        bin_nxt  = bin_p1 - ONE;
        wrap_nxt = (bin_p1 == '0);
      end
    end
  end

  // Stage p1: counter registers. Gray is registered from the next binary
  // value so both outputs change on the same edge with no output glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_p1  <= INIT_BIN;
      gray_p1 <= bin2gray(INIT_BIN);
      wrap_p1 <= 1'b0;
    end else begin
      bin_p1  <= bin_nxt;
      gray_p1 <= bin2gray(bin_nxt);
      wrap_p1 <= wrap_nxt;
    end
  end

`ifdef GRAY_COUNTER_DECODE_EN
  // Conversion datapath: direction chosen per request.
  always_comb begin
    conv_res = bin2gray(conv_din);
    if (conv_mode) begin
      conv_res = gray2bin(conv_din);
    end
  end
`else
  // Encode-only datapath; conv_mode is kept on the port list but unused.
  logic conv_mode_unused;
  assign conv_mode_unused = conv_mode;

  // Conversion datapath: always binary->Gray.
  always_comb begin
    conv_res = bin2gray(conv_din);
  end
`endif

  // Stage p1: conversion result; data holds when no request arrives, and a
  // reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      conv_p1 <= '0;
    end else begin
      vld_p1 <= conv_valid_in;
      if (conv_valid_in) begin
        conv_p1 <= conv_res;
      end
    end
  end

  assign bin_out        = bin_p1;
  assign gray_out       = gray_p1;
  assign wrap           = wrap_p1;
  assign conv_valid_out = vld_p1;
  assign conv_dout      = conv_p1;

endmodule
